// File: rtl/branch_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_queue
// Purpose  : In-order issue queue for branch/JAL/JALR micro-ops with CDB
//            operand wakeup; issues the head entry to the branch unit.
// Revision : 1.0
// ============================================================================
module branch_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_disp_valid,
    output logic                          o_disp_ready,
    input  logic [3:0]                    i_disp_alu_op,
    input  logic [DATA_WIDTH-1:0]         i_disp_pc,
    input  logic [DATA_WIDTH-1:0]         i_disp_imm,
    input  logic [ROB_WIDTH-1:0]          i_disp_rob_tag,
    input  logic [DATA_WIDTH-1:0]         i_disp_op1,
    input  logic                          i_disp_op1_ready,
    input  logic [ROB_WIDTH-1:0]          i_disp_op1_tag,
    input  logic [DATA_WIDTH-1:0]         i_disp_op2,
    input  logic                          i_disp_op2_ready,
    input  logic [ROB_WIDTH-1:0]          i_disp_op2_tag,
    input  logic                          i_cdb_valid,
    input  logic [ROB_WIDTH-1:0]          i_cdb_tag,
    input  logic [DATA_WIDTH-1:0]         i_cdb_data,
    input  logic                          i_flush,
    output logic                          o_issue_valid,
    output logic [3:0]                    o_issue_alu_op,
    output logic [DATA_WIDTH-1:0]         o_issue_pc,
    output logic [DATA_WIDTH-1:0]         o_issue_imm,
    output logic [DATA_WIDTH-1:0]         o_issue_op1,
    output logic [DATA_WIDTH-1:0]         o_issue_op2,
    output logic [ROB_WIDTH-1:0]          o_issue_rob_tag,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0]       c_op_jal  = 4'b1100;
    localparam logic [3:0]       c_op_jalr = 4'b1101;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic                  r_valid    [DEPTH];
    logic [3:0]            r_alu_op   [DEPTH];
    logic [DATA_WIDTH-1:0] r_pc       [DEPTH];
    logic [DATA_WIDTH-1:0] r_imm      [DEPTH];
    logic [ROB_WIDTH-1:0]  r_rob_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] r_op1      [DEPTH];
    logic                  r_op1_rdy  [DEPTH];
    logic [ROB_WIDTH-1:0]  r_op1_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] r_op2      [DEPTH];
    logic                  r_op2_rdy  [DEPTH];
    logic [ROB_WIDTH-1:0]  r_op2_tag  [DEPTH];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_disp_we;
    logic                  w_issue;
    logic                  w_is_jal;
    logic                  w_is_jalr;
    logic                  w_op1_wake;
    logic                  w_op2_wake;
    logic                  w_op1_src_rdy;
    logic                  w_op2_src_rdy;
    logic                  w_op1_rdy_in;
    logic                  w_op2_rdy_in;
    logic [DATA_WIDTH-1:0] w_op1_in;
    logic [DATA_WIDTH-1:0] w_op2_in;

    assign o_disp_ready = (r_count < c_depth);
    assign w_disp_we    = i_disp_valid && o_disp_ready && !i_flush;

    assign w_is_jal  = (i_disp_alu_op == c_op_jal);
    assign w_is_jalr = (i_disp_alu_op == c_op_jalr);

    // JAL reads no register and JALR reads only rs1, so those operands are
    // treated as present regardless of what dispatch reports.
    assign w_op1_src_rdy = i_disp_op1_ready || w_is_jal;
    assign w_op2_src_rdy = i_disp_op2_ready || w_is_jal || w_is_jalr;
    assign w_op1_wake    = i_cdb_valid && (i_cdb_tag == i_disp_op1_tag);
    assign w_op2_wake    = i_cdb_valid && (i_cdb_tag == i_disp_op2_tag);
    assign w_op1_rdy_in  = w_op1_src_rdy || w_op1_wake;
    assign w_op2_rdy_in  = w_op2_src_rdy || w_op2_wake;
    assign w_op1_in      = (!w_op1_src_rdy && w_op1_wake) ? i_cdb_data : i_disp_op1;
    assign w_op2_in      = (!w_op2_src_rdy && w_op2_wake) ? i_cdb_data : i_disp_op2;

    assign w_issue = r_valid[r_head] && r_op1_rdy[r_head] && r_op2_rdy[r_head] && !i_flush;

    assign o_issue_valid   = w_issue;
    assign o_issue_alu_op  = r_alu_op[r_head];
    assign o_issue_pc      = r_pc[r_head];
    assign o_issue_imm     = r_imm[r_head];
    assign o_issue_op1     = r_op1[r_head];
    assign o_issue_op2     = r_op2[r_head];
    assign o_issue_rob_tag = r_rob_tag[r_head];
    assign o_count         = r_count;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_wr_sel;
            logic w_iss_sel;
            logic w_op1_cap;
            logic w_op2_cap;

            assign w_wr_sel  = w_disp_we && (r_tail == PTR_W'(gi));
            assign w_iss_sel = w_issue && (r_head == PTR_W'(gi));
            assign w_op1_cap = r_valid[gi] && !r_op1_rdy[gi] && i_cdb_valid
                               && (i_cdb_tag == r_op1_tag[gi]);
            assign w_op2_cap = r_valid[gi] && !r_op2_rdy[gi] && i_cdb_valid
                               && (i_cdb_tag == r_op2_tag[gi]);

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid[gi]   <= 1'b0;
                    r_alu_op[gi]  <= '0;
                    r_pc[gi]      <= '0;
                    r_imm[gi]     <= '0;
                    r_rob_tag[gi] <= '0;
                    r_op1[gi]     <= '0;
                    r_op1_rdy[gi] <= 1'b0;
                    r_op1_tag[gi] <= '0;
                    r_op2[gi]     <= '0;
                    r_op2_rdy[gi] <= 1'b0;
                    r_op2_tag[gi] <= '0;
                end else if (i_flush) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_wr_sel) begin
                    // The tail slot is never valid when written, so it can
                    // neither issue nor capture from the CDB this cycle.
                    r_valid[gi]   <= 1'b1;
                    r_alu_op[gi]  <= i_disp_alu_op;
                    r_pc[gi]      <= i_disp_pc;
                    r_imm[gi]     <= i_disp_imm;
                    r_rob_tag[gi] <= i_disp_rob_tag;
                    r_op1[gi]     <= w_op1_in;
                    r_op1_rdy[gi] <= w_op1_rdy_in;
                    r_op1_tag[gi] <= i_disp_op1_tag;
                    r_op2[gi]     <= w_op2_in;
                    r_op2_rdy[gi] <= w_op2_rdy_in;
                    r_op2_tag[gi] <= i_disp_op2_tag;
                end else begin
                    if (w_iss_sel) begin
                        r_valid[gi] <= 1'b0;
                    end
                    if (w_op1_cap) begin
                        r_op1[gi]     <= i_cdb_data;
                        r_op1_rdy[gi] <= 1'b1;
                    end
                    if (w_op2_cap) begin
                        r_op2[gi]     <= i_cdb_data;
                        r_op2_rdy[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_disp_we) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_issue) begin
                r_head <= r_head + c_ptr_one;
            end
            case ({w_disp_we, w_issue})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_issue_queue
// Purpose  : Directed self-checking bench for branch_issue_queue.
// Revision : 1.0
// ============================================================================
module tb_branch_issue_queue;

    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  rst;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [3:0]            disp_alu_op;
    logic [DATA_WIDTH-1:0] disp_pc;
    logic [DATA_WIDTH-1:0] disp_imm;
    logic [ROB_WIDTH-1:0]  disp_rob_tag;
    logic [DATA_WIDTH-1:0] disp_op1;
    logic                  disp_op1_ready;
    logic [ROB_WIDTH-1:0]  disp_op1_tag;
    logic [DATA_WIDTH-1:0] disp_op2;
    logic                  disp_op2_ready;
    logic [ROB_WIDTH-1:0]  disp_op2_tag;
    logic                  cdb_valid;
    logic [ROB_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  flush;
    logic                  issue_valid;
    logic [3:0]            issue_alu_op;
    logic [DATA_WIDTH-1:0] issue_pc;
    logic [DATA_WIDTH-1:0] issue_imm;
    logic [DATA_WIDTH-1:0] issue_op1;
    logic [DATA_WIDTH-1:0] issue_op2;
    logic [ROB_WIDTH-1:0]  issue_rob_tag;
    logic [2:0]            count;

    int checks = 0;
    int errors = 0;

    branch_issue_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .ROB_WIDTH (ROB_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_disp_valid    (disp_valid),
        .o_disp_ready    (disp_ready),
        .i_disp_alu_op   (disp_alu_op),
        .i_disp_pc       (disp_pc),
        .i_disp_imm      (disp_imm),
        .i_disp_rob_tag  (disp_rob_tag),
        .i_disp_op1      (disp_op1),
        .i_disp_op1_ready(disp_op1_ready),
        .i_disp_op1_tag  (disp_op1_tag),
        .i_disp_op2      (disp_op2),
        .i_disp_op2_ready(disp_op2_ready),
        .i_disp_op2_tag  (disp_op2_tag),
        .i_cdb_valid     (cdb_valid),
        .i_cdb_tag       (cdb_tag),
        .i_cdb_data      (cdb_data),
        .i_flush         (flush),
        .o_issue_valid   (issue_valid),
        .o_issue_alu_op  (issue_alu_op),
        .o_issue_pc      (issue_pc),
        .o_issue_imm     (issue_imm),
        .o_issue_op1     (issue_op1),
        .o_issue_op2     (issue_op2),
        .o_issue_rob_tag (issue_rob_tag),
        .o_count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid     = 1'b0;
        disp_alu_op    = 4'd0;
        disp_pc        = '0;
        disp_imm       = '0;
        disp_rob_tag   = '0;
        disp_op1       = '0;
        disp_op1_ready = 1'b0;
        disp_op1_tag   = '0;
        disp_op2       = '0;
        disp_op2_ready = 1'b0;
        disp_op2_tag   = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        flush          = 1'b0;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [3:0] rob,
                              input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                              input logic [31:0] v2, input logic r2, input logic [3:0] t2);
        disp_valid     = 1'b1;
        disp_alu_op    = op;
        disp_pc        = pc;
        disp_imm       = imm;
        disp_rob_tag   = rob;
        disp_op1       = v1;
        disp_op1_ready = r1;
        disp_op1_tag   = t1;
        disp_op2       = v2;
        disp_op2_ready = r2;
        disp_op2_tag   = t2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
        checks++; if (issue_pc !== 32'h0) begin errors++; $display("FAIL reset_issue_pc: got %h expected 0", issue_pc); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ready_dispatch();
        drive_disp(4'b0000, 32'h100, 32'h20, 4'd3, 32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rd_same_cycle: got %b expected 0", issue_valid); end
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL rd_issue_valid: got %b expected 1", issue_valid); end
        checks++; if (issue_op1 !== 32'd5 || issue_op2 !== 32'd5) begin errors++; $display("FAIL rd_ops: got %h/%h expected 5/5", issue_op1, issue_op2); end
        checks++; if (issue_pc !== 32'h100 || issue_imm !== 32'h20) begin errors++; $display("FAIL rd_pc_imm: got %h/%h expected 100/20", issue_pc, issue_imm); end
        checks++; if (issue_rob_tag !== 4'd3 || issue_alu_op !== 4'b0000) begin errors++; $display("FAIL rd_tag_op: got %h/%h expected 3/0", issue_rob_tag, issue_alu_op); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rd_count1: got %0d expected 1", count); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rd_count0: got %0d expected 0", count); end
    endtask

    task automatic test_wakeup();
        drive_disp(4'b0100, 32'h140, 32'h8, 4'd4, 32'd7, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9);
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wk_wait: got %b expected 0", issue_valid); end
        step();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd9;
        cdb_data  = 32'hFFFF_FFFF;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wk_no_bypass: got %b expected 0", issue_valid); end
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wk_issue: got %b expected 1", issue_valid); end
        checks++; if (issue_op2 !== 32'hFFFF_FFFF || issue_op1 !== 32'd7) begin errors++; $display("FAIL wk_ops: got %h/%h expected 7/ffffffff", issue_op1, issue_op2); end
        step();
    endtask

    task automatic test_disp_wakeup();
        drive_disp(4'b0001, 32'h180, 32'h10, 4'd5, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd2;
        cdb_data  = 32'h44;
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL dw_issue: got %b expected 1", issue_valid); end
        checks++; if (issue_op1 !== 32'h44) begin errors++; $display("FAIL dw_op1: got %h expected 44", issue_op1); end
        step();
    endtask

    task automatic test_jal_jalr();
        drive_disp(4'b1100, 32'h1C0, 32'h40, 4'd6, 32'd0, 1'b0, 4'd7, 32'd0, 1'b0, 4'd8);
        step();
        drive_disp(4'b1101, 32'h1C4, 32'h4, 4'd7, 32'h33, 1'b1, 4'd0, 32'd0, 1'b0, 4'd8);
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_alu_op !== 4'b1100) begin errors++; $display("FAIL jal_issue: got %b/%h expected 1/c", issue_valid, issue_alu_op); end
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd7) begin errors++; $display("FAIL jalr_issue: got %b/%h expected 1/7", issue_valid, issue_rob_tag); end
        checks++; if (issue_op1 !== 32'h33) begin errors++; $display("FAIL jalr_op1: got %h expected 33", issue_op1); end
        step();
    endtask

    // Five entries have been dispatched so far, so this fill wraps the pointers.
    task automatic test_full_in_order();
        drive_disp(4'b0000, 32'h200, 32'h0, 4'd10, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0);
        step();
        drive_disp(4'b0001, 32'h204, 32'h0, 4'd11, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        step();
        drive_disp(4'b0101, 32'h208, 32'h0, 4'd12, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        step();
        drive_disp(4'b0110, 32'h20C, 32'h0, 4'd13, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        step();
        drive_disp(4'b0111, 32'h210, 32'h0, 4'd14, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        #1;
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", disp_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_head_block: got %b expected 0", issue_valid); end
        step();
        idle();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignored: got %0d expected 4", count); end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd6;
        cdb_data  = 32'h66;
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd10 || issue_op1 !== 32'h66) begin errors++; $display("FAIL order0: got %b/%h/%h expected 1/a/66", issue_valid, issue_rob_tag, issue_op1); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd11) begin errors++; $display("FAIL order1: got %b/%h expected 1/b", issue_valid, issue_rob_tag); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd12) begin errors++; $display("FAIL order2: got %b/%h expected 1/c", issue_valid, issue_rob_tag); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 4'd13 || issue_pc !== 32'h20C) begin errors++; $display("FAIL order3: got %b/%h/%h expected 1/d/20c", issue_valid, issue_rob_tag, issue_pc); end
        step();
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %0d/%b expected 0/0", count, issue_valid); end
    endtask

    task automatic test_flush();
        drive_disp(4'b0000, 32'h300, 32'h0, 4'd1, 32'd0, 1'b0, 4'd4, 32'd2, 1'b1, 4'd0);
        step();
        drive_disp(4'b0000, 32'h304, 32'h0, 4'd2, 32'd0, 1'b0, 4'd5, 32'd2, 1'b1, 4'd0);
        step();
        drive_disp(4'b0000, 32'h308, 32'h0, 4'd3, 32'd0, 1'b0, 4'd5, 32'd2, 1'b1, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        cdb_data  = 32'h77;
        step();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL fl_pre: got %b/%0d expected 1/3", issue_valid, count); end
        flush = 1'b1;
        drive_disp(4'b0000, 32'h30C, 32'h0, 4'd8, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'h55;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fl_suppress: got %b expected 0", issue_valid); end
        step();
        idle();
        #1;
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL fl_after: got %0d/%b expected 0/0", count, issue_valid); end
        step();
        step();
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL fl_quiet: got %0d/%b expected 0/0", count, issue_valid); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive_disp(4'b0000, 32'h400 + 32'(k), 32'h0, 4'(k), 32'd0, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0);
            step();
        end
        idle();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_pre: got %0d expected 3", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", count); end
        checks++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin errors++; $display("FAIL ar_flags: got %b/%b expected 0/1", issue_valid, disp_ready); end
        checks++; if (issue_pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h expected 0", issue_pc); end
        step();
        rst = 1'b0;
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_post: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_disp_wakeup();
        test_jal_jalr();
        test_full_in_order();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
